// File: rtl/riscy_mem_arbiter.sv
// riscy_mem_arbiter: shares one OBI-style memory port between instruction fetch and data.
// Data has priority. A streak limit lets a waiting fetch win after MAX_DATA_STREAK data grants.
// Each accepted request pushes its master ID into an in-order queue, so responses route back.
module riscy_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               instr_req_i,
    input  logic [31:0]                        instr_addr_i,
    output logic                               instr_gnt_o,
    output logic                               instr_rvalid_o,
    output logic [31:0]                        instr_rdata_o,
    input  logic                               data_req_i,
    input  logic                               data_we_i,
    input  logic [3:0]                         data_be_i,
    input  logic [31:0]                        data_addr_i,
    input  logic [31:0]                        data_wdata_i,
    output logic                               data_gnt_o,
    output logic                               data_rvalid_o,
    output logic [31:0]                        data_rdata_o,
    output logic                               mem_req_o,
    output logic                               mem_we_o,
    output logic [3:0]                         mem_be_o,
    output logic [31:0]                        mem_addr_o,
    output logic [31:0]                        mem_wdata_o,
    input  logic                               mem_gnt_i,
    input  logic                               mem_rvalid_i,
    input  logic [31:0]                        mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);

    localparam int unsigned PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    logic [MAX_OUTSTANDING-1:0] id_q;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [STREAK_W-1:0]        streak;
    logic                       err;

    logic full;
    logic empty;
    logic sel_instr;
    logic sel_data;
    logic push;
    logic pop;
    logic head_id;
    logic streak_max;

    // Selection, request mux, grants and response routing.
    always_comb begin
        full       = 1'b0;
        empty      = 1'b0;
        streak_max = 1'b0;
        sel_instr  = 1'b0;
        sel_data   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        head_id    = 1'b0;

        full       = (count == CNT_W'(MAX_OUTSTANDING));
        empty      = (count == '0);
        streak_max = (streak == STREAK_W'(MAX_DATA_STREAK));
        sel_instr  = instr_req_i & (~data_req_i | streak_max);
        sel_data   = data_req_i & ~sel_instr;
        head_id    = id_q[rd_ptr];

        mem_req_o   = (instr_req_i | data_req_i) & ~full & ~rst_i;
        mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
        mem_we_o    = sel_data ? data_we_i    : 1'b0;
        mem_be_o    = sel_data ? data_be_i    : 4'hF;
        mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

        instr_gnt_o = mem_req_o & mem_gnt_i & sel_instr;
        data_gnt_o  = mem_req_o & mem_gnt_i & ~sel_instr;
        push        = mem_req_o & mem_gnt_i;
        pop         = mem_rvalid_i & ~empty & ~rst_i;

        instr_rvalid_o = pop & ~head_id;
        data_rvalid_o  = pop & head_id;
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;

        outstanding_o = rst_i ? '0 : count;
        err_o         = err & ~rst_i;
    end

    // Outstanding-ID queue: push on accepted request, pop on response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                id_q[wr_ptr] <= ~sel_instr;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Data-streak counter bounding how long a waiting fetch can be held off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak <= '0;
        end else if (!instr_req_i || instr_gnt_o) begin
            streak <= '0;
        end else if (data_gnt_o && !streak_max) begin
            streak <= streak + STREAK_W'(1);
        end
    end

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else if (mem_rvalid_i && empty) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// Testbench for riscy_mem_arbiter: directed table, contention sequence and random run vs. a queue-based model.
module tb_riscy_mem_arbiter;

    localparam int MAXO = 4;
    localparam int MAXS = 4;

    typedef struct {
        bit        rst;
        bit        ireq;
        bit [31:0] iaddr;
        bit        dreq;
        bit        dwe;
        bit [3:0]  dbe;
        bit [31:0] daddr;
        bit [31:0] dwdata;
        bit        gnt;
        bit        rv;
        bit [31:0] rdata;
    } stim_t;

    typedef struct {
        stim_t s;
        bit    mreq;
        bit    igr;
        bit    dgr;
        bit    irv;
        bit    drv;
        int    outst;
        bit    err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [2:0]  outstanding;
    logic        err;

    riscy_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .MAX_DATA_STREAK(MAXS)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .outstanding_o(outstanding), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: queue of master IDs (0 = instr, 1 = data), streak count, sticky error.
    bit m_q[$];
    int m_streak = 0;
    bit m_err    = 0;

    // Snapshot of DUT outputs taken mid-cycle.
    bit s_mreq, s_igr, s_dgr, s_irv, s_drv, s_err;
    int s_outst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle, compare against the model, then advance the model at the clock edge.
    task automatic run_cycle(input stim_t s);
        bit full, si, sd, mreq, igr, dgr, irv, drv, popq;
        rst = s.rst; instr_req = s.ireq; instr_addr = s.iaddr;
        data_req = s.dreq; data_we = s.dwe; data_be = s.dbe; data_addr = s.daddr;
        data_wdata = s.dwdata; mem_gnt = s.gnt; mem_rvalid = s.rv; mem_rdata = s.rdata;
        #2;
        full = (m_q.size() == MAXO);
        si   = s.ireq && (!s.dreq || m_streak == MAXS);
        sd   = s.dreq && !si;
        mreq = (s.ireq || s.dreq) && !full && !s.rst;
        igr  = mreq && s.gnt && si;
        dgr  = mreq && s.gnt && !si;
        popq = s.rv && m_q.size() > 0 && !s.rst;
        irv  = popq && m_q[0] == 1'b0;
        drv  = popq && m_q[0] == 1'b1;
        chk("mem_req", 32'(mem_req), 32'(mreq));
        chk("instr_gnt", 32'(instr_gnt), 32'(igr));
        chk("data_gnt", 32'(data_gnt), 32'(dgr));
        chk("mem_addr", mem_addr, sd ? s.daddr : s.iaddr);
        chk("mem_we", 32'(mem_we), sd ? 32'(s.dwe) : 32'd0);
        chk("mem_be", 32'(mem_be), sd ? 32'(s.dbe) : 32'hF);
        chk("mem_wdata", mem_wdata, sd ? s.dwdata : 32'd0);
        chk("instr_rvalid", 32'(instr_rvalid), 32'(irv));
        chk("data_rvalid", 32'(data_rvalid), 32'(drv));
        chk("instr_rdata", instr_rdata, s.rdata);
        chk("data_rdata", data_rdata, s.rdata);
        chk("outstanding", 32'(outstanding), s.rst ? 32'd0 : 32'(m_q.size()));
        chk("err", 32'(err), 32'(m_err && !s.rst));
        s_mreq = mem_req; s_igr = instr_gnt; s_dgr = data_gnt;
        s_irv = instr_rvalid; s_drv = data_rvalid; s_err = err; s_outst = int'(outstanding);
        @(posedge clk);
        if (s.rst) begin
            m_q.delete();
            m_streak = 0;
            m_err    = 0;
        end else begin
            if (s.rv && m_q.size() == 0) m_err = 1;
            if (popq) void'(m_q.pop_front());
            if (igr || dgr) m_q.push_back(dgr);
            if (!s.ireq || igr) m_streak = 0;
            else if (dgr && m_streak < MAXS) m_streak++;
        end
        @(negedge clk);
        cyc++;
    endtask

    function automatic stim_t st(bit r, bit ireq, bit [31:0] ia, bit dreq, bit we, bit [3:0] be,
                                 bit [31:0] da, bit [31:0] wd, bit gnt, bit rv, bit [31:0] rd);
        stim_t s;
        s.rst = r; s.ireq = ireq; s.iaddr = ia; s.dreq = dreq; s.dwe = we; s.dbe = be;
        s.daddr = da; s.dwdata = wd; s.gnt = gnt; s.rv = rv; s.rdata = rd;
        return s;
    endfunction

    function automatic vec_t v(stim_t s, bit mreq, bit igr, bit dgr, bit irv, bit drv,
                               int outst, bit e);
        vec_t x;
        x.s = s; x.mreq = mreq; x.igr = igr; x.dgr = dgr; x.irv = irv; x.drv = drv;
        x.outst = outst; x.err = e;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        stim_t idle, rst_s, s;
        idle  = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_s = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; instr_req = 0; instr_addr = 0; data_req = 0; data_we = 0; data_be = 0;
        data_addr = 0; data_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        // Directed table: inputs, then mreq igr dgr irv drv outstanding err.
        tbl.push_back(v(st(0,1,32'h80,0,0,0,0,0,1,0,0),                   1,1,0,0,0,0,0));
        tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'h00500093),             0,0,0,1,0,1,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,0,0));
        tbl.push_back(v(st(0,0,0,1,1,4'b0011,32'h100,32'hDEADBEEF,1,0,0),  1,0,1,0,0,0,0));
        tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'h11),                    0,0,0,0,1,1,0));
        tbl.push_back(v(st(0,1,32'h84,0,0,0,0,0,1,0,0),                   1,1,0,0,0,0,0));
        tbl.push_back(v(st(0,0,0,1,0,4'hF,32'h200,0,1,0,0),                1,0,1,0,0,1,0));
        tbl.push_back(v(st(0,1,32'h88,0,0,0,0,0,1,0,0),                   1,1,0,0,0,2,0));
        tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'hAAAA0001),              0,0,0,1,0,3,0));
        tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'hBBBB0002),              0,0,0,0,1,2,0));
        tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'hCCCC0003),              0,0,0,1,0,1,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(st(0,1,32'h90,0,0,0,0,0,1,0,0),               1,1,0,0,0,k,0));
        tbl.push_back(v(st(0,1,32'h90,0,0,0,0,0,1,1,32'h1234),            0,0,0,1,0,4,0));
        tbl.push_back(v(st(0,1,32'h94,0,0,0,0,0,1,0,0),                   1,1,0,0,0,3,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,4,0));
        for (int k = 4; k > 0; k--)
            tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'h55),                0,0,0,1,0,k,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,0,0));
        tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'h66),                    0,0,0,0,0,0,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,0,1));
        tbl.push_back(v(st(0,1,32'hA0,0,0,0,0,0,1,0,0),                   1,1,0,0,0,0,1));
        tbl.push_back(v(st(0,0,0,1,0,4'hF,32'h300,0,1,0,0),                1,0,1,0,0,1,1));
        tbl.push_back(v(rst_s,                                             0,0,0,0,0,0,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,0,0));
        tbl.push_back(v(st(0,0,0,0,0,0,0,0,0,1,32'h77),                    0,0,0,0,0,0,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,0,1));
        tbl.push_back(v(rst_s,                                             0,0,0,0,0,0,0));
        tbl.push_back(v(idle,                                              0,0,0,0,0,0,0));

        @(negedge clk);
        run_cycle(rst_s);
        run_cycle(rst_s);
        chk("reset_outstanding", 32'(s_outst), 32'd0);
        chk("reset_err", 32'(s_err), 32'd0);

        foreach (tbl[i]) begin
            run_cycle(tbl[i].s);
            chk("tbl_mem_req", 32'(s_mreq), 32'(tbl[i].mreq));
            chk("tbl_instr_gnt", 32'(s_igr), 32'(tbl[i].igr));
            chk("tbl_data_gnt", 32'(s_dgr), 32'(tbl[i].dgr));
            chk("tbl_instr_rvalid", 32'(s_irv), 32'(tbl[i].irv));
            chk("tbl_data_rvalid", 32'(s_drv), 32'(tbl[i].drv));
            chk("tbl_outstanding", 32'(s_outst), 32'(tbl[i].outst));
            chk("tbl_err", 32'(s_err), 32'(tbl[i].err));
        end

        // Contention: both masters request continuously; grants must go D,D,D,D,I.
        for (int i = 0; i < 15; i++) begin
            s = st(0, 1, 32'h400, 1, 0, 4'hF, 32'h800, 0, 1, i > 0, 32'(i));
            run_cycle(s);
            chk("contention_instr_gnt", 32'(s_igr), 32'(i % 5 == 4));
            chk("contention_data_gnt", 32'(s_dgr), 32'(i % 5 != 4));
        end

        // Randomized traffic, including occasional resets and stray responses.
        for (int i = 0; i < 3000; i++) begin
            s.rst    = ($urandom_range(0, 199) == 0);
            s.ireq   = ($urandom_range(0, 3) != 0);
            s.iaddr  = $urandom;
            s.dreq   = ($urandom_range(0, 2) != 0);
            s.dwe    = $urandom_range(0, 1);
            s.dbe    = 4'($urandom);
            s.daddr  = $urandom;
            s.dwdata = $urandom;
            s.gnt    = ($urandom_range(0, 3) != 0);
            s.rv     = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
            s.rdata  = $urandom;
            run_cycle(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
